// File: rtl/aging_fifo_pkg.sv
// Shared constants and elaboration helpers for the aging-sensor sample FIFO.
// Pulled in with import aging_fifo_pkg::* by the RAM and the FIFO top.
package aging_fifo_pkg;

  localparam int AGING_FIFO_DATA_W = 8;
  localparam int AGING_FIFO_DEPTH  = 16;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >>> 1;
    end
    return res;
  endfunction

  // Legal geometry: power-of-2 depth >= 2, AF in 1..DEPTH, AE in 0..DEPTH-1.
  function automatic bit fifo_cfg_ok(input int depth, input int af, input int ae);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/aging_fifo_ram.sv
// DEPTH x DATA_W simple dual-port storage: synchronous write port,
// asynchronous read port so the FIFO head can be shown ahead of the read.
module aging_fifo_ram
  import aging_fifo_pkg::*;
#(
  parameter int DATA_W = AGING_FIFO_DATA_W,
  parameter int DEPTH  = AGING_FIFO_DEPTH,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              i_clock,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: the array deliberately has no reset; the pointers define which
  // entries are valid, and a reset port would prevent RAM inference.
  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/aging_fifo_param.sv
// Parametrised show-ahead FIFO for aging-sensor samples: occupancy count,
// almost-full/empty thresholds and sticky overflow/underflow flags.
module aging_fifo_param
  import aging_fifo_pkg::*;
#(
  parameter int DATA_W    = AGING_FIFO_DATA_W,
  parameter int DEPTH     = AGING_FIFO_DEPTH,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2,
  parameter int AW        = clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              sclr,
  input  logic              wrreq,
  input  logic [DATA_W-1:0] data,
  input  logic              rdreq,
  input  logic              clr_err,
  output logic [DATA_W-1:0] q,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       usedw,
  output logic              overflow,
  output logic              underflow
);

  generate
    if (!fifo_cfg_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_cfg
      $error("aging_fifo_param: illegal DEPTH/AF_THRESH/AE_THRESH combination");
    end
  endgenerate

  localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] AF_LV   = AF_THRESH[AW:0];
  localparam logic [AW:0] AE_LV   = AE_THRESH[AW:0];

  // Pointers carry a wrap bit above the index so full and empty differ.
  logic [AW:0]       r_wp;
  logic [AW:0]       r_rp;
  logic              r_overflow;
  logic              r_underflow;

  logic [AW:0]       w_usedw;
  logic              w_empty;
  logic              w_full;
  logic              w_rd_ok;
  logic              w_wr_ok;
  logic              w_ovf_set;
  logic              w_unf_set;
  logic [DATA_W-1:0] w_rdata;

  assign w_usedw = r_wp - r_rp;
  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);

  // A read frees a slot in the same edge, so a full FIFO still takes a write.
  assign w_rd_ok   = rdreq && !w_empty;
  assign w_wr_ok   = wrreq && (!w_full || w_rd_ok);
  assign w_ovf_set = wrreq && !w_wr_ok;
  assign w_unf_set = rdreq && !w_rd_ok;

  aging_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .i_clock (clock),
    .i_we    (w_wr_ok && !sclr),
    .i_waddr (r_wp[AW-1:0]),
    .i_wdata (data),
    .i_raddr (r_rp[AW-1:0]),
    .o_rdata (w_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clock) begin
    if (sclr) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wp <= r_wp + PTR_INC;
      if (w_rd_ok) r_rp <= r_rp + PTR_INC;
      // A new error in the clearing cycle keeps its flag set.
      r_overflow  <= w_ovf_set || (r_overflow  && !clr_err);
      r_underflow <= w_unf_set || (r_underflow && !clr_err);
    end
  end

  assign q            = w_empty ? '0 : w_rdata;
  assign full         = w_full;
  assign empty        = w_empty;
  assign usedw        = w_usedw;
  assign almost_full  = (w_usedw >= AF_LV);
  assign almost_empty = (w_usedw <= AE_LV);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_aging_fifo_param.sv
// Scoreboard bench: a 16x8 instance with default thresholds and a 8x12
// instance with edge thresholds (AF=DEPTH, AE=0), both checked every cycle.
module tb_aging_fifo_param;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A: DATA_W=8, DEPTH=16, AF=12, AE=2
  logic        a_sclr = 1'b0, a_wrreq = 1'b0, a_rdreq = 1'b0, a_clr_err = 1'b0;
  logic [7:0]  a_data = '0, a_q;
  logic        a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [4:0]  a_usedw;

  // Instance B: DATA_W=12, DEPTH=8, AF=8, AE=0
  logic        b_sclr = 1'b0, b_wrreq = 1'b0, b_rdreq = 1'b0, b_clr_err = 1'b0;
  logic [11:0] b_data = '0, b_q;
  logic        b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [3:0]  b_usedw;

  aging_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(2)) dut_a (
    .clock(clock), .sclr(a_sclr), .wrreq(a_wrreq), .data(a_data), .rdreq(a_rdreq),
    .clr_err(a_clr_err), .q(a_q), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .usedw(a_usedw),
    .overflow(a_ovf), .underflow(a_unf)
  );

  aging_fifo_param #(.DATA_W(12), .DEPTH(8), .AF_THRESH(8), .AE_THRESH(0)) dut_b (
    .clock(clock), .sclr(b_sclr), .wrreq(b_wrreq), .data(b_data), .rdreq(b_rdreq),
    .clr_err(b_clr_err), .q(b_q), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .usedw(b_usedw),
    .overflow(b_ovf), .underflow(b_unf)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboards: words pushed on accepted writes, popped on accepted reads.
  logic [7:0]  sb_a[$];
  logic [11:0] sb_b[$];
  bit ovf_a = 0, unf_a = 0, ovf_b = 0, unf_b = 0;

  task automatic check_a();
    int n;
    n = sb_a.size();
    check("a_usedw", 32'(a_usedw), 32'(n));
    check("a_empty", 32'(a_empty), 32'(n == 0));
    check("a_full",  32'(a_full),  32'(n == 16));
    check("a_af",    32'(a_af),    32'(n >= 12));
    check("a_ae",    32'(a_ae),    32'(n <= 2));
    check("a_q",     32'(a_q),     (n == 0) ? 32'h0 : 32'(sb_a[0]));
    check("a_ovf",   32'(a_ovf),   32'(ovf_a));
    check("a_unf",   32'(a_unf),   32'(unf_a));
  endtask

  task automatic check_b();
    int n;
    n = sb_b.size();
    check("b_usedw", 32'(b_usedw), 32'(n));
    check("b_empty", 32'(b_empty), 32'(n == 0));
    check("b_full",  32'(b_full),  32'(n == 8));
    check("b_af",    32'(b_af),    32'(n >= 8));
    check("b_ae",    32'(b_ae),    32'(n <= 0));
    check("b_q",     32'(b_q),     (n == 0) ? 32'h0 : 32'(sb_b[0]));
    check("b_ovf",   32'(b_ovf),   32'(ovf_b));
    check("b_unf",   32'(b_unf),   32'(unf_b));
  endtask

  // One clock of instance A: drive, update the model, clock, then compare.
  task automatic cyc_a(input bit wr, input logic [7:0] d, input bit rd, input bit clr, input bit rst);
    bit rd_ok, wr_ok;
    logic [7:0] head;
    a_wrreq = wr; a_data = d; a_rdreq = rd; a_clr_err = clr; a_sclr = rst;
    if (rst) begin
      sb_a.delete();
      ovf_a = 0;
      unf_a = 0;
    end else begin
      rd_ok = rd && (sb_a.size() != 0);
      wr_ok = wr && ((sb_a.size() != 16) || rd_ok);
      if (rd_ok) begin
        head = sb_a.pop_front();
        check("a_rd_word", 32'(a_q), 32'(head));
      end
      if (wr_ok) sb_a.push_back(d);
      ovf_a = (wr && !wr_ok) || (ovf_a && !clr);
      unf_a = (rd && !rd_ok) || (unf_a && !clr);
    end
    @(posedge clock);
    #1;
    a_wrreq = 0; a_rdreq = 0; a_clr_err = 0; a_sclr = 0;
    check_a();
  endtask

  task automatic cyc_b(input bit wr, input logic [11:0] d, input bit rd, input bit clr, input bit rst);
    bit rd_ok, wr_ok;
    logic [11:0] head;
    b_wrreq = wr; b_data = d; b_rdreq = rd; b_clr_err = clr; b_sclr = rst;
    if (rst) begin
      sb_b.delete();
      ovf_b = 0;
      unf_b = 0;
    end else begin
      rd_ok = rd && (sb_b.size() != 0);
      wr_ok = wr && ((sb_b.size() != 8) || rd_ok);
      if (rd_ok) begin
        head = sb_b.pop_front();
        check("b_rd_word", 32'(b_q), 32'(head));
      end
      if (wr_ok) sb_b.push_back(d);
      ovf_b = (wr && !wr_ok) || (ovf_b && !clr);
      unf_b = (rd && !rd_ok) || (unf_b && !clr);
    end
    @(posedge clock);
    #1;
    b_wrreq = 0; b_rdreq = 0; b_clr_err = 0; b_sclr = 0;
    check_b();
  endtask

  initial begin
    // Reset then idle.
    cyc_b(0, '0, 0, 0, 1);
    cyc_a(0, '0, 0, 0, 1);
    cyc_a(0, '0, 0, 0, 1);
    cyc_a(0, '0, 0, 0, 0);

    // Back-to-back fill 0x00..0x0F, then drain in order.
    for (int i = 0; i < 16; i++) cyc_a(1, 8'(i), 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc_a(0, '0, 1, 0, 0);

    // Full with simultaneous read+write: 0xAA lands behind 0x01..0x0F.
    for (int i = 0; i < 16; i++) cyc_a(1, 8'(i), 0, 0, 0);
    cyc_a(1, 8'hAA, 1, 0, 0);
    for (int i = 0; i < 16; i++) cyc_a(0, '0, 1, 0, 0);

    // Overflow and underflow, then clear; set-wins when clear collides.
    for (int i = 0; i < 16; i++) cyc_a(1, 8'(8'h20 + i), 0, 0, 0);
    cyc_a(1, 8'h55, 0, 0, 0);
    cyc_a(0, '0, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc_a(0, '0, 1, 0, 0);
    cyc_a(0, '0, 1, 0, 0);
    cyc_a(0, '0, 0, 1, 0);
    cyc_a(0, '0, 1, 0, 0);
    cyc_a(0, '0, 1, 1, 0);
    cyc_a(0, '0, 0, 1, 0);

    // Simultaneous read+write on empty: write taken, read flagged.
    cyc_a(1, 8'h9D, 1, 0, 0);
    cyc_a(0, '0, 1, 1, 0);

    // Reset mid-burst with requests pending, then one-cycle write visibility.
    for (int i = 0; i < 5; i++) cyc_a(1, 8'(8'h40 + i), 0, 0, 0);
    cyc_a(1, 8'h77, 1, 0, 1);
    cyc_a(1, 8'h3C, 0, 0, 0);
    cyc_a(0, '0, 1, 0, 0);

    // Instance B: random interleave across pointer rollovers.
    cyc_b(0, '0, 0, 0, 1);
    for (int i = 0; i < 40; i++)
      cyc_b(bit'($urandom_range(0, 99) < 60), 12'($urandom), bit'($urandom_range(0, 99) < 50), 0, 0);
    for (int i = 0; i < 9; i++) cyc_b(1, 12'(12'hA00 + i), 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc_b(0, '0, 1, 0, 0);
    cyc_b(0, '0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/aging_fifo_param.md
Name: aging_fifo_param

Overview:
Parametrised synchronous show-ahead FIFO, the next generation of the aging-sensor sample buffer. It is generalised in data width and depth. It adds an occupancy count, programmable almost-full/almost-empty thresholds, a write-on-full-with-read pass, and sticky overflow/underflow error flags. It sits between the aging sensor counters (writer) and the bus/readout logic (reader), in a single clock domain.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; must be a power of 2, >=2
AF_THRESH, 12, almost_full asserts when usedw >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserts when usedw <= AE_THRESH (0..DEPTH-1)

Ports:
clock  input  1  single clock; all state updates on rising edge
sclr  input  1  synchronous reset, active-high
wrreq  input  1  write request
data  input  DATA_W  write data, sampled with wrreq
rdreq  input  1  read request (acknowledges current q)
q  output  DATA_W  show-ahead head-of-FIFO word
full  output  1  usedw == DEPTH
empty  output  1  usedw == 0
almost_full  output  1  usedw >= AF_THRESH
almost_empty  output  1  usedw <= AE_THRESH
usedw  output  AW+1  current occupancy 0..DEPTH, where AW = clog2(DEPTH)
overflow  output  1  sticky: a write was rejected
underflow  output  1  sticky: a read was rejected
clr_err  input  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (sclr=1 at edge): wp=rp=0, wrap bits=0, overflow=underflow=0. Memory contents are not reset.
  - Outputs after reset: empty=1, full=0, usedw=0, almost_full=0, almost_empty=1, q=0.
- sclr has priority over all requests and over clr_err. A reset mid-burst discards all contents; requests in that cycle are ignored and set no error flag.
- Pointers: wp/rp are AW-bit indices plus a wrap bit each (AW+1-bit counters); DEPTH is a power of 2, so wrap is natural rollover.
  - usedw = {w_wrap,wp} - {r_wrap,rp} modulo 2^(AW+1).
  - full/empty are decoded from index equality plus wrap-bit compare.
- Read accepted (rd_ok) = rdreq & !empty. rp advances by 1 at the edge.
- Write accepted (wr_ok) = wrreq & (!full | rd_ok). mem[wp] <= data and wp advances.
  - Simultaneous read and write while full: both accepted, usedw stays DEPTH.
  - Simultaneous read and write while empty: write accepted, read rejected (underflow=1), usedw becomes 1.
- usedw update per cycle: +1 on write only, -1 on read only, unchanged on both or neither.
- Show-ahead read: q = mem[rp] combinationally when !empty, q = 0 when empty.
  - A write into an empty FIFO is visible on q the cycle after the write edge (one-cycle write-to-read latency).
  - On rd_ok, q presents the next word in the following cycle.
- All flags are combinational decodes of registered pointers: no glitch from request inputs, and none is a function of wrreq/rdreq.
- Errors:
  - overflow <= 1 when wrreq & !wr_ok.
  - underflow <= 1 when rdreq & !rd_ok.
  - Both are held until clr_err or sclr.
  - If clr_err and a new error occur in the same cycle, the flag ends at 1 (set wins).
  - Rejected operations never modify pointers or memory.
- Threshold edge values: AF_THRESH=DEPTH makes almost_full equal full; AE_THRESH=0 makes almost_empty equal empty.

Decomposition:
- Package aging_fifo_pkg:
  - clog2 constant function.
  - Default constants AGING_FIFO_DATA_W=8 and AGING_FIFO_DEPTH=16.
  - Elaboration-time checks (DEPTH power of 2; AF_THRESH/AE_THRESH ranges) as a shared assertion macro/function.
- One sub-module, aging_fifo_ram: DEPTH x DATA_W simple dual-port array, synchronous write (we, waddr, wdata), asynchronous read (raddr -> rdata), no reset. The top holds pointers, flags, the error logic and the q=0 masking.

Test Plan:
- Reset then idle -> empty=1, almost_empty=1, full=0, usedw=0, q=0, overflow=underflow=0.
- DEPTH=16: write 0x00..0x0F back-to-back, then read 16 -> full=1 and usedw=16 after write 16; almost_full=1 from usedw=12; q sequence 0x00..0x0F in order; empty=1 at end.
- Fill to 16, then assert wrreq (0xAA) and rdreq together -> both accepted, usedw=16; 0xAA read out last after 0x01..0x0F.
- Write to full, extra wrreq 0x55; read empty, extra rdreq -> overflow=1 and underflow=1; pointers unchanged; 0x55 never appears; clr_err pulse clears both.
- Wrap-around: 40 interleaved cycles with random wrreq/rdreq (DATA_W=12, DEPTH=8) -> scoreboard matches q order; usedw equals model count every cycle across pointer rollovers.
- With usedw=5, assert sclr together with wrreq and rdreq -> next cycle usedw=0, empty=1, no error flags set; the following write of 0x3C is visible on q one cycle later.
